lpc_synth_sequencer: RTL and testbench

- Frame-level controller for the LPC synthesis filter.
- Accepts per-frame parameters: 11 coefficients, gain, pitch period and voiced flag. Coefficients are written into a shadow bank.
- Drives the filter's coefficient bus, excitation sample and valid strobe at a fixed sample rate, then captures the filter output.
- Sits between the frame decoder and the audio output path.

---
 rtl/lpc_synth_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_lpc_synth_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_synth_sequencer.sv
// LPC synthesis frame sequencer: shadow/active coefficient banks, sample pacing,
// excitation generation (impulse train or LFSR noise) and filter output capture.
// Ports: coef_wr/coef_addr/coef_data fill the shadow bank; frm_* is the frame
//   handshake; A0..A10, fx, fv drive the filter; fy, fvout come back from it;
//   sample/sample_valid carry the captured output; running/underrun report status.
module lpc_synth_sequencer #(
  parameter int          SAMPLE_DIV = 6250,
  parameter int          FRAME_LEN  = 160,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coef_wr,
  input  logic [3:0]  coef_addr,
  input  logic [15:0] coef_data,
  input  logic        frm_valid,
  output logic        frm_ready,
  input  logic [15:0] frm_gain,
  input  logic [7:0]  frm_pitch,
  input  logic        frm_voiced,
  output logic [15:0] A0,
  output logic [15:0] A1,
  output logic [15:0] A2,
  output logic [15:0] A3,
  output logic [15:0] A4,
  output logic [15:0] A5,
  output logic [15:0] A6,
  output logic [15:0] A7,
  output logic [15:0] A8,
  output logic [15:0] A9,
  output logic [15:0] A10,
  output logic [15:0] fx,
  output logic        fv,
  input  logic [15:0] fy,
  input  logic        fvout,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        running,
  output logic        underrun
);

  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SAMPLE_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FRAME_LEN - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state;
  logic          pending;

  logic [15:0]   sh_coef [11];
  logic [15:0]   sh_gain;
  logic [7:0]    sh_pitch;
  logic          sh_voiced;

  logic [15:0]   act_coef [11];
  logic [15:0]   act_gain;
  logic [7:0]    act_pitch;
  logic          act_voiced;

  logic [DW-1:0] div;
  logic [CW-1:0] cnt;
  logic [7:0]    phase;
  logic [15:0]   lfsr;

  logic          accept;
  logic          frame_end;
  logic          commit;
  logic          issue;
  logic          restart;
  logic          lfsr_fb;
  logic [7:0]    new_pitch;
  logic [7:0]    phase_inc;
  logic signed [31:0] prod;
  logic [15:0]   noise;
  logic [15:0]   exc;

  assign accept    = frm_valid & ~pending;
  assign frame_end = (state == S_RUN) & (div == DIV_MAX)
                   & (cnt == CNT_MAX);
  assign commit    = pending & ((state == S_IDLE) | frame_end);
  assign issue     = (state == S_RUN) & (div == '0);

  // pitch 0 behaves as 1; active pitch is stored already normalised
  assign new_pitch = (sh_pitch == 8'd0) ? 8'd1 : sh_pitch;

  // phase survives a frame boundary only if it still fits the new period
  assign restart = (new_pitch <= phase) | (~act_voiced & sh_voiced);

  assign phase_inc = (({1'b0, phase} + 9'd1) >= {1'b0, act_pitch})
                   ? 8'd0 : phase + 8'd1;

  // Fibonacci taps 16,14,13,11 in right-shift form
  assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

  assign prod  = $signed(act_gain) * $signed(lfsr);
  assign noise = 16'(prod >>> 15);

  assign exc = act_voiced
             ? ((phase == 8'd0) ? act_gain : 16'd0)
             : noise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 11; i++) sh_coef[i] <= '0;
      sh_gain   <= '0;
      sh_pitch  <= '0;
      sh_voiced <= 1'b0;
    end else begin
      // writes are dropped while a frame waits so it cannot be corrupted
      if (coef_wr & ~pending) begin
        for (int i = 0; i < 11; i++) begin
          if (coef_addr == 4'(i)) sh_coef[i] <= coef_data;
        end
      end
      if (accept) begin
        sh_gain   <= frm_gain;
        sh_pitch  <= frm_pitch;
        sh_voiced <= frm_voiced;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      pending    <= 1'b0;
      div        <= '0;
      cnt        <= '0;
      phase      <= '0;
      lfsr       <= LFSR_SEED;
      for (int i = 0; i < 11; i++) act_coef[i] <= '0;
      act_gain   <= '0;
      act_pitch  <= '0;
      act_voiced <= 1'b0;
      fx         <= '0;
      fv         <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      fv <= issue;

      if (issue) begin
        fx <= exc;
        if (act_voiced) phase <= phase_inc;
        else            lfsr  <= {lfsr_fb, lfsr[15:1]};
      end

      if (accept) pending <= 1'b1;

      // a frame ending with nothing queued wins over a same-cycle accept
      if (frame_end & ~pending) underrun <= 1'b1;
      else if (accept)          underrun <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (commit) begin
            state <= S_RUN;
            div   <= '0;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          if (div == DIV_MAX) begin
            div <= '0;
            if (cnt == CNT_MAX) begin
              cnt <= '0;
              if (!pending) begin
                state <= S_IDLE;
                fx    <= '0;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            div <= div + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (commit) begin
        pending <= 1'b0;
        for (int i = 0; i < 11; i++) act_coef[i] <= sh_coef[i];
        act_gain   <= sh_gain;
        act_pitch  <= new_pitch;
        act_voiced <= sh_voiced;
        if (restart) phase <= '0;
      end
    end
  end

  // filter results are captured in any state so the last one is kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= fvout;
      if (fvout) sample <= fy;
    end
  end

  assign frm_ready = ~pending;
  assign running   = (state == S_RUN);

  assign A0  = act_coef[0];
  assign A1  = act_coef[1];
  assign A2  = act_coef[2];
  assign A3  = act_coef[3];
  assign A4  = act_coef[4];
  assign A5  = act_coef[5];
  assign A6  = act_coef[6];
  assign A7  = act_coef[7];
  assign A8  = act_coef[8];
  assign A9  = act_coef[9];
  assign A10 = act_coef[10];

endmodule

// File: tb/tb_lpc_synth_sequencer.sv
// Randomised self-checking bench for lpc_synth_sequencer with a
// frame-time reference model and a per-cycle compare process.
module tb_lpc_synth_sequencer;

  localparam int SD = 8;
  localparam int FL = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coef_wr = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic        frm_valid = 1'b0;
  logic        frm_ready;
  logic [15:0] frm_gain = '0;
  logic [7:0]  frm_pitch = '0;
  logic        frm_voiced = 1'b0;
  logic [15:0] a [11];
  logic [15:0] fx;
  logic        fv;
  logic [15:0] fy = '0;
  logic        fvout = 1'b0;
  logic [15:0] sample;
  logic        sample_valid;
  logic        running;
  logic        underrun;

  lpc_synth_sequencer #(
    .SAMPLE_DIV(SD), .FRAME_LEN(FL), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .frm_valid(frm_valid), .frm_ready(frm_ready),
    .frm_gain(frm_gain), .frm_pitch(frm_pitch), .frm_voiced(frm_voiced),
    .A0(a[0]), .A1(a[1]), .A2(a[2]), .A3(a[3]), .A4(a[4]), .A5(a[5]),
    .A6(a[6]), .A7(a[7]), .A8(a[8]), .A9(a[9]), .A10(a[10]),
    .fx(fx), .fv(fv), .fy(fy), .fvout(fvout),
    .sample(sample), .sample_valid(sample_valid),
    .running(running), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  bit checking = 0;
  bit force_vout = 0;
  logic [15:0] fxq[$];
  int tq[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] noise_of(input logic [15:0] g,
                                           input logic [15:0] l);
    int p;
    logic [31:0] q;
    p = int'($signed(g)) * int'($signed(l));
    q = p >>> 15;
    return q[15:0];
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  // reference model: tracks elapsed cycles since a run started
  logic [15:0] s_coef [11];
  logic [15:0] e_a [11];
  logic [15:0] s_gain, m_gain, e_fx, e_sample, m_lfsr;
  int s_pitch, m_pitch, m_phase, m_t;
  bit s_voiced, m_voiced, m_run, m_pend, e_fv, e_sv, e_und;

  always @(posedge clk or negedge rst) begin : model
    bit acc, fe, com, iss;
    int np;
    if (!rst) begin
      for (int i = 0; i < 11; i++) begin
        s_coef[i] = '0;
        e_a[i] = '0;
      end
      s_gain = '0; m_gain = '0; e_fx = '0; e_sample = '0;
      m_lfsr = SEED; s_pitch = 0; m_pitch = 1; m_phase = 0; m_t = 0;
      s_voiced = 0; m_voiced = 0; m_run = 0; m_pend = 0;
      e_fv = 0; e_sv = 0; e_und = 0;
    end else begin
      acc = frm_valid && !m_pend;
      fe  = m_run && (m_t == SD * FL - 1);
      com = m_pend && (!m_run || fe);
      iss = m_run && (m_t % SD == 0);
      e_fv = iss;
      e_sv = fvout;
      if (fvout) e_sample = fy;
      if (iss) begin
        if (m_voiced) begin
          e_fx = (m_phase == 0) ? m_gain : 16'h0;
          m_phase = (m_phase + 1) % m_pitch;
        end else begin
          e_fx = noise_of(m_gain, m_lfsr);
          m_lfsr = lfsr_step(m_lfsr);
        end
      end
      if (fe && !m_pend) begin
        e_und = 1;
        e_fx = '0;
      end else if (acc) begin
        e_und = 0;
      end
      if (com) begin
        np = (s_pitch == 0) ? 1 : s_pitch;
        if (np <= m_phase || (!m_voiced && s_voiced)) m_phase = 0;
        for (int i = 0; i < 11; i++) e_a[i] = s_coef[i];
        m_gain = s_gain; m_pitch = np; m_voiced = s_voiced;
      end
      if (m_run) begin
        if (fe) begin
          m_t = 0;
          m_run = com;
        end else begin
          m_t++;
        end
      end else if (com) begin
        m_run = 1;
        m_t = 0;
      end
      if (coef_wr && !m_pend && int'(coef_addr) < 11)
        s_coef[int'(coef_addr)] = coef_data;
      if (acc) begin
        s_gain = frm_gain;
        s_pitch = int'(frm_pitch);
        s_voiced = frm_voiced;
      end
      if (com) m_pend = 0;
      if (acc) m_pend = 1;
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("frm_ready", frm_ready, !m_pend);
      chk("running", running, m_run);
      chk("underrun", underrun, e_und);
      chk("fv", fv, e_fv);
      if (e_fv) chk("fx", fx, e_fx);
      chk("sample_valid", sample_valid, e_sv);
      chk("sample", sample, e_sample);
      for (int i = 0; i < 11; i++) chk($sformatf("A%0d", i), a[i], e_a[i]);
      if (fv) begin
        fxq.push_back(fx);
        tq.push_back(cyc);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    fvout = fv | force_vout;
    fy = force_vout ? 16'h1234 : 16'($urandom);
  endtask

  task automatic wr(input int ad, input logic [15:0] d);
    coef_wr = 1; coef_addr = 4'(ad); coef_data = d;
    step();
    coef_wr = 0;
  endtask

  task automatic send_frame(input logic [15:0] g, input int p, input bit v);
    int n = 0;
    while (!frm_ready && n < 400) begin step(); n++; end
    chk("ready_wait", frm_ready, 1);
    frm_valid = 1; frm_gain = g; frm_pitch = 8'(p); frm_voiced = v;
    step();
    frm_valid = 0;
  endtask

  task automatic wait_run(input bit want, input string nm);
    int n = 0;
    while (running !== want && n < 600) begin step(); n++; end
    chk(nm, running, want);
  endtask

  task automatic wait_fv();
    int n = 0;
    while (fv !== 1'b1 && n < 100) begin step(); n++; end
    chk("fv_wait", fv, 1);
  endtask

  task automatic capture_check(input string nm);
    force_vout = 1;
    step();
    force_vout = 0;
    step();
    chk({nm, "_sv_hi"}, sample_valid, 1);
    chk({nm, "_sample"}, sample, 16'h1234);
    step();
    chk({nm, "_sv_lo"}, sample_valid, 0);
  endtask

  logic [15:0] exp4 [4] = '{16'h4000, 16'h0000, 16'h0000, 16'h4000};

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    #2 rst = 0;
    checking = 1;
    repeat (3) step();
    chk("rst_ready", frm_ready, 1);
    chk("rst_fx", fx, 0);
    #2 rst = 1;
    repeat (2) step();

    for (int i = 0; i < 11; i++) wr(i, 16'(16'h0100 * i));
    fxq.delete(); tq.delete();
    send_frame(16'h4000, 3, 1);
    wait_run(1, "f1_start");
    wait_run(0, "f1_end");
    chk("f1_A5", a[5], 16'h0500);
    chk("f1_fv_count", fxq.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < fxq.size()) chk($sformatf("f1_fx%0d", i), fxq[i], exp4[i]);
    for (int i = 1; i < tq.size(); i++) chk("f1_gap", tq[i] - tq[i-1], SD);
    chk("f1_underrun", underrun, 1);

    fxq.delete(); tq.delete();
    send_frame(16'($urandom), 2, 1);
    wait_run(1, "b2b_start");
    repeat (5) step();
    chk("b2b_und_clr", underrun, 0);
    send_frame(16'($urandom), 3, 1);
    chk("b2b_ready_low", frm_ready, 0);
    wait_run(0, "b2b_end");
    chk("b2b_fv_count", fxq.size(), 8);
    for (int i = 1; i < tq.size(); i++) chk("b2b_gap", tq[i] - tq[i-1], SD);

    fxq.delete(); tq.delete();
    for (int k = 0; k < 4; k++) send_frame(16'h7FFF, $urandom_range(0, 9), 0);
    wait_run(0, "uv_end");
    chk("uv_count", fxq.size(), 16);
    if (fxq.size() > 0) chk("uv_first", fxq[0], 16'hACE1);

    for (int i = 0; i < 11; i++) wr(i, 16'(16'h1000 + i));
    send_frame(16'h2000, 4, 1);
    wait_run(1, "prot_start");
    for (int i = 0; i < 11; i++) wr(i, 16'(16'h2000 + i));
    wr(12, 16'hBEEF);
    send_frame(16'h3000, 5, 1);
    chk("prot_pending", frm_ready, 0);
    wr(2, 16'hDEAD);
    wr(12, 16'hBEEF);
    wait_run(0, "prot_end");
    for (int i = 0; i < 11; i++)
      chk($sformatf("prot_A%0d", i), a[i], 16'(16'h2000 + i));

    capture_check("cap_idle");
    send_frame(16'h1111, 2, 1);
    wait_run(1, "cap_run_start");
    wait_fv();
    step();
    capture_check("cap_run");

    #2 rst = 0;
    step();
    chk("mid_rst_running", running, 0);
    chk("mid_rst_fv", fv, 0);
    chk("mid_rst_fx", fx, 0);
    chk("mid_rst_sample", sample, 0);
    chk("mid_rst_ready", frm_ready, 1);
    for (int i = 0; i < 11; i++) chk($sformatf("mid_rst_A%0d", i), a[i], 0);
    step();
    #2 rst = 1;
    n = 0;
    repeat (50) begin
      step();
      if (fv) n++;
    end
    chk("post_rst_no_fv", n, 0);

    repeat (40) begin
      repeat ($urandom_range(0, 4)) wr($urandom_range(0, 15), 16'($urandom));
      repeat ($urandom_range(0, 40)) step();
      if ($urandom_range(0, 3) == 0) begin
        frm_valid = 1; frm_gain = 16'($urandom);
        frm_pitch = 8'($urandom_range(0, 5)); frm_voiced = 1'($urandom);
        step();
        frm_valid = 0;
      end
      send_frame(16'($urandom), $urandom_range(0, 5), 1'($urandom));
    end
    wait_run(0, "rand_end");
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
